// File: rtl/pipe_pkg.sv
// Shared types for the decode/issue interlock: scoreboard entry layout and
// forward-select encoding.
package pipe_pkg;

  // Widest register address a scoreboard entry can hold; REG_AW must not exceed it.
  localparam int unsigned MAX_AW = 8;

  // Forward-select value meaning "take the operand from the register file".
  localparam int unsigned SEL_RF = 0;

  typedef struct packed {
    logic              valid;
    logic [MAX_AW-1:0] rd;
    logic              we;
    logic              is_load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Compares one decode source register against every in-flight stage and
// reports the youngest producer plus whether that producer is a not-yet-ready load.
module hazard_match
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned SEL_W      = 2
) (
  input  logic                  use_src,
  input  logic [REG_AW-1:0]     src,
  input  sb_entry_t [DEPTH-1:0] entries,
  output logic [SEL_W-1:0]      sel,
  output logic                  load_hazard
);

  // Oldest-to-youngest scan so the youngest match is the last one written.
  always_comb begin
    sel         = SEL_W'(SEL_RF);
    load_hazard = 1'b0;
    for (int unsigned k = DEPTH; k >= 1; k--) begin
      if (use_src && (src != '0) && entries[k-1].valid && entries[k-1].we &&
          (entries[k-1].rd == MAX_AW'(src))) begin
        sel         = SEL_W'(k);
        load_hazard = entries[k-1].is_load && (k < LOAD_STAGE);
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// In-order pipeline interlock: tracks in-flight destinations, selects operand
// forwarding, inserts load-use bubbles and kills decode on a taken branch.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dec_valid,
  input  logic [REG_AW-1:0]          dec_rs1,
  input  logic [REG_AW-1:0]          dec_rs2,
  input  logic [REG_AW-1:0]          dec_rd,
  input  logic                       dec_use_rs1,
  input  logic                       dec_use_rs2,
  input  logic                       dec_we,
  input  logic                       dec_is_load,
  input  logic                       branch_taken,
  output logic                       issue,
  output logic                       stall,
  output logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] fwd_rs1_sel,
  output logic [$clog2(DEPTH+1)-1:0] fwd_rs2_sel,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt
);

  localparam int unsigned SEL_W = $clog2(DEPTH + 1);

  sb_entry_t [DEPTH-1:0] sb;
  sb_entry_t             dec_entry;
  logic [SEL_W-1:0]      sel1, sel2;
  logic                  lh1, lh2;
  logic                  active;

  // Nothing in decode, or reset in progress, means no hazard and no forwarding.
  assign active = dec_valid && !reset;

  hazard_match #(
    .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)
  ) u_match_rs1 (
    .use_src(active && dec_use_rs1), .src(dec_rs1), .entries(sb),
    .sel(sel1), .load_hazard(lh1)
  );

  hazard_match #(
    .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)
  ) u_match_rs2 (
    .use_src(active && dec_use_rs2), .src(dec_rs2), .entries(sb),
    .sel(sel2), .load_hazard(lh2)
  );

  always_comb begin
    flush       = branch_taken;
    stall       = (lh1 || lh2) && !branch_taken;
    issue       = dec_valid && !stall && !flush;
    fwd_rs1_sel = sel1;
    fwd_rs2_sel = sel2;
    dec_entry.valid   = 1'b1;
    dec_entry.rd      = MAX_AW'(dec_rd);
    dec_entry.we      = dec_we;
    dec_entry.is_load = dec_is_load;
  end

  // Scoreboard shifts every cycle; stage 1 gets the issued instruction or a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb <= '0;
    end else begin
      for (int unsigned k = DEPTH - 1; k >= 1; k--) begin
        sb[k] <= sb[k-1];
      end
      sb[0] <= issue ? dec_entry : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected outputs are queued with each step and
// checked on the following falling edge.
module tb_pipe_ctrl;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned SEL_W  = 2;

  typedef struct {
    logic       issue;
    logic       stall;
    logic       flush;
    logic [1:0] sel1;
    logic [1:0] sel2;
    int         scnt;
    int         fcnt;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              dec_valid;
  logic [REG_AW-1:0] dec_rs1, dec_rs2, dec_rd;
  logic              dec_use_rs1, dec_use_rs2, dec_we, dec_is_load;
  logic              branch_taken;
  logic              issue, stall, flush;
  logic [SEL_W-1:0]  fwd_rs1_sel, fwd_rs2_sel;
  logic [15:0]       stall_cnt, flush_cnt;

  logic              s_issue, s_stall, s_flush;
  logic [SEL_W-1:0]  s_sel1, s_sel2;
  logic [1:0]        s_stall_cnt, s_flush_cnt;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_we(dec_we), .dec_is_load(dec_is_load), .branch_taken(branch_taken),
    .issue(issue), .stall(stall), .flush(flush),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter copy on the same inputs, used for the saturation check.
  pipe_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_we(dec_we), .dec_is_load(dec_is_load), .branch_taken(branch_taken),
    .issue(s_issue), .stall(s_stall), .flush(s_flush),
    .fwd_rs1_sel(s_sel1), .fwd_rs2_sel(s_sel2),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic step(input string name,
                      input logic rst, input logic v,
                      input int rs1, input int rs2, input int rd,
                      input logic u1, input logic u2, input logic we,
                      input logic ld, input logic br,
                      input logic ei, input logic es, input logic ef,
                      input int e1, input int e2, input int esc, input int efc);
    exp_t e, g;
    reset        = rst;
    dec_valid    = v;
    dec_rs1      = REG_AW'(rs1);
    dec_rs2      = REG_AW'(rs2);
    dec_rd       = REG_AW'(rd);
    dec_use_rs1  = u1;
    dec_use_rs2  = u2;
    dec_we       = we;
    dec_is_load  = ld;
    branch_taken = br;
    e.issue = ei; e.stall = es; e.flush = ef;
    e.sel1 = 2'(e1); e.sel2 = 2'(e2); e.scnt = esc; e.fcnt = efc;
    exp_q.push_back(e);
    @(negedge clk);
    g = exp_q.pop_front();
    chk({name, ".issue"}, int'(issue), int'(g.issue));
    chk({name, ".stall"}, int'(stall), int'(g.stall));
    chk({name, ".flush"}, int'(flush), int'(g.flush));
    chk({name, ".fwd_rs1_sel"}, int'(fwd_rs1_sel), int'(g.sel1));
    chk({name, ".fwd_rs2_sel"}, int'(fwd_rs2_sel), int'(g.sel2));
    chk({name, ".stall_cnt"}, int'(stall_cnt), g.scnt);
    chk({name, ".flush_cnt"}, int'(flush_cnt), g.fcnt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0; dec_we = 1'b0; dec_is_load = 1'b0;
    branch_taken = 1'b0;
    @(posedge clk);
    #1;
    //            name        rst v  rs1 rs2 rd u1 u2 we ld br   iss stl fls s1 s2 sc fc
    step("reset",       1, 0,  0,  0,  0, 0, 0, 0, 0, 0,   0,  0,  0,  0, 0, 0, 0);
    step("add_x3",      0, 1,  1,  2,  3, 1, 1, 1, 0, 0,   1,  0,  0,  0, 0, 0, 0);
    step("use_x3",      0, 1,  3,  0,  6, 1, 0, 1, 0, 0,   1,  0,  0,  1, 0, 0, 0);
    step("lw_x5",       0, 1,  6,  0,  5, 1, 0, 1, 1, 0,   1,  0,  0,  1, 0, 0, 0);
    step("lu_stall",    0, 1,  6,  5,  7, 1, 1, 1, 0, 0,   0,  1,  0,  2, 1, 0, 0);
    step("lu_release",  0, 1,  6,  5,  7, 1, 1, 1, 0, 0,   1,  0,  0,  0, 2, 1, 0);
    step("add_x4",      0, 1,  0,  0,  4, 0, 0, 1, 0, 0,   1,  0,  0,  0, 0, 1, 0);
    step("sub_x4",      0, 1,  0,  0,  4, 0, 0, 1, 0, 0,   1,  0,  0,  0, 0, 1, 0);
    step("youngest_x4", 0, 1,  4,  0,  0, 1, 0, 1, 0, 0,   1,  0,  0,  1, 0, 1, 0);
    step("read_x0",     0, 1,  0,  0,  9, 1, 1, 1, 1, 0,   1,  0,  0,  0, 0, 1, 0);
    step("lu_flush",    0, 1,  9,  0,  1, 1, 0, 1, 0, 1,   0,  0,  1,  1, 0, 1, 0);
    step("no_valid",    0, 0,  9,  9,  1, 1, 1, 1, 0, 0,   0,  0,  0,  0, 0, 1, 1);
    step("lw_x10",      0, 1,  0,  0, 10, 0, 0, 1, 1, 0,   1,  0,  0,  0, 0, 1, 1);
    step("stall_x10",   0, 1, 10,  0, 11, 1, 0, 1, 0, 0,   0,  1,  0,  1, 0, 1, 1);
    step("rst_in_stall",1, 1, 10,  0, 11, 1, 0, 1, 0, 0,   1,  0,  0,  0, 0, 2, 1);
    step("post_reset",  0, 1, 10,  0, 11, 1, 0, 1, 0, 0,   1,  0,  0,  0, 0, 0, 0);
    step("branch",      0, 1,  0,  0,  0, 0, 0, 0, 0, 1,   0,  0,  1,  0, 0, 0, 0);
    step("idle",        0, 0,  0,  0,  0, 0, 0, 0, 0, 0,   0,  0,  0,  0, 0, 0, 1);

    // Five more flush cycles: wide counter reaches 6, 2-bit copy holds at 3.
    for (int i = 0; i < 5; i++) begin
      branch_taken = 1'b1;
      @(posedge clk);
      #1;
    end
    branch_taken = 1'b0;
    @(negedge clk);
    chk("flush_cnt_wide", int'(flush_cnt), 6);
    chk("flush_cnt_sat", int'(s_flush_cnt), 3);
    chk("stall_cnt_sat", int'(s_stall_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
